// File: rtl/mac_accum_if.sv
// ============================================================================
// Module      : mac_accum_if
// Description : Product-in / result-out handshake bundle for mac_accum.
//               The master side feeds products and consumes results; the
//               slave side is the accumulator itself.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mac_accum_if #(
  parameter int P     = 9,
  parameter int ACC_W = 12
) ();

  logic [P-1:0]     prod_in;
  logic             prod_valid;
  logic             prod_ready;
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic             acc_ready;
  logic             ovf;

  modport master (
    output prod_in,
    output prod_valid,
    output acc_ready,
    input  prod_ready,
    input  acc_out,
    input  acc_valid,
    input  ovf
  );

  modport slave (
    input  prod_in,
    input  prod_valid,
    input  acc_ready,
    output prod_ready,
    output acc_out,
    output acc_valid,
    output ovf
  );

endinterface

`default_nettype wire

// File: rtl/mac_accum.sv
// ============================================================================
// Module      : mac_accum
// Description : Signed multiply-accumulate back end. Sums K consecutive
//               signed products into an ACC_W-bit result presented on a
//               valid/ready port, with sticky per-group overflow flag.
//               Optional macro MAC_ACCUM_SAT_EN: saturate instead of wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_accum #(
  parameter int N     = 4,
  parameter int M     = 5,
  parameter int P     = N + M,
  parameter int K     = 4,
  parameter int ACC_W = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  mac_accum_if.slave bus
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ACCUM = 2'd1;
  localparam logic [1:0] c_HOLD  = 2'd2;

  // Term index of the last product of a group (cnt holds terms already taken).
  localparam logic [7:0] c_K_LAST = 8'(K - 1);

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q,   acc_d;
  logic [7:0]       cnt_q,   cnt_d;
  logic             ovf_q,   ovf_d;

  logic [P-1:0]     w_prod;
  logic [ACC_W-1:0] w_sext;
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] w_add_res;
  logic             w_add_ovf;
  logic             w_prod_ready;
  logic             w_accept;

  assign w_prod = bus.prod_in;

  // Sign-extend the product to accumulator width (no-op when widths match).
  generate
    if (ACC_W > P) begin : g_sext_wide
      assign w_sext = {{(ACC_W-P){w_prod[P-1]}}, w_prod};
    end else begin : g_sext_same
      assign w_sext = w_prod[ACC_W-1:0];
    end
  endgenerate

  // Signed overflow: both operands share a sign that the sum does not.
  assign w_sum     = acc_q + w_sext;
  assign w_add_ovf = (acc_q[ACC_W-1] == w_sext[ACC_W-1]) &&
                     (w_sum[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef MAC_ACCUM_SAT_EN
  localparam logic [ACC_W-1:0] c_SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Clamp toward the operands' common sign on overflow.
  assign w_add_res = w_add_ovf ? (w_sext[ACC_W-1] ? c_SAT_MIN : c_SAT_MAX)
                               : w_sum;
`else
  // Plain modulo-2^ACC_W wrap; the flag still records the overflow.
  assign w_add_res = w_sum;
`endif

  // Handshake decodes: clear blocks both accepting and presenting.
  assign w_prod_ready  = !clear && ((state_q == c_IDLE) || (state_q == c_ACCUM));
  assign w_accept      = bus.prod_valid && w_prod_ready;
  assign bus.prod_ready = w_prod_ready;
  assign bus.acc_valid  = !clear && (state_q == c_HOLD);
  assign bus.acc_out    = acc_q;
  assign bus.ovf        = ovf_q;

  // Next-state logic for the group sequencer and accumulator.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = c_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        c_IDLE: begin
          if (w_accept) begin
            acc_d   = w_sext;
            cnt_d   = 8'd1;
            ovf_d   = 1'b0;
            state_d = (K == 1) ? c_HOLD : c_ACCUM;
          end
        end
        c_ACCUM: begin
          if (w_accept) begin
            acc_d = w_add_res;
            cnt_d = cnt_q + 8'd1;
            ovf_d = ovf_q | w_add_ovf;
            if (cnt_q == c_K_LAST) begin
              state_d = c_HOLD;
            end
          end
        end
        c_HOLD: begin
          if (bus.acc_ready) begin
            state_d = c_IDLE;
          end
        end
        default: begin
          state_d = c_IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mac_accum.sv
// ============================================================================
// Module      : tb_mac_accum
// Description : Self-checking bench for mac_accum. Instance A uses ACC_W=12,
//               instance B uses ACC_W=10 for overflow groups. Expected values
//               follow the MAC_ACCUM_SAT_EN macro when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_accum;

  logic clk = 1'b0;
  logic rst;
  logic clear;

  always #5 clk = ~clk;

  mac_accum_if #(.P(9), .ACC_W(12)) ifa ();
  mac_accum_if #(.P(9), .ACC_W(10)) ifb ();

  mac_accum #(.N(4), .M(5), .K(4), .ACC_W(12)) u_dut_a (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (ifa.slave)
  );

  mac_accum #(.N(4), .M(5), .K(4), .ACC_W(10)) u_dut_b (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (ifb.slave)
  );

  typedef struct packed {
    logic            sel;      // 0: instance A, 1: instance B
    logic [3:0][8:0] t;        // t[0] is the first term
    logic [11:0]     exp_acc;
    logic            exp_ovf;
  } vec_t;

  vec_t vecs [7];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic sel, input logic v, input logic [8:0] d, input logic ar);
    if (sel) begin
      ifb.prod_valid = v;
      ifb.prod_in    = d;
      ifb.acc_ready  = ar;
    end else begin
      ifa.prod_valid = v;
      ifa.prod_in    = d;
      ifa.acc_ready  = ar;
    end
    #1;
  endtask

  function automatic logic rd_pready(input logic sel);
    return sel ? ifb.prod_ready : ifa.prod_ready;
  endfunction

  function automatic logic rd_valid(input logic sel);
    return sel ? ifb.acc_valid : ifa.acc_valid;
  endfunction

  function automatic logic rd_ovf(input logic sel);
    return sel ? ifb.ovf : ifa.ovf;
  endfunction

  function automatic logic [11:0] rd_acc(input logic sel);
    return sel ? {2'b00, ifb.acc_out} : ifa.acc_out;
  endfunction

  function automatic vec_t mk(input logic sel, input logic [8:0] a, input logic [8:0] b,
                              input logic [8:0] c, input logic [8:0] d,
                              input logic [11:0] acc, input logic ovf);
    vec_t v;
    v.sel     = sel;
    v.t[0]    = a;
    v.t[1]    = b;
    v.t[2]    = c;
    v.t[3]    = d;
    v.exp_acc = acc;
    v.exp_ovf = ovf;
    return v;
  endfunction

  // Feed four terms to instance A back to back, checking each is accepted.
  task automatic feed_a(input logic [8:0] a, input logic [8:0] b,
                        input logic [8:0] c, input logic [8:0] d, input logic ar);
    logic [3:0][8:0] tt;
    tt = {d, c, b, a};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, tt[i], ar);
      chk("feed_pready", {11'd0, rd_pready(1'b0)}, 12'd1);
      tick();
    end
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    for (int i = 0; i < 4; i++) begin
      drive(v.sel, 1'b1, v.t[i], 1'b1);
      chk($sformatf("v%0d_pready_t%0d", idx, i), {11'd0, rd_pready(v.sel)}, 12'd1);
      tick();
    end
    drive(v.sel, 1'b0, 9'd0, 1'b1);
    chk($sformatf("v%0d_valid", idx), {11'd0, rd_valid(v.sel)}, 12'd1);
    chk($sformatf("v%0d_acc", idx), rd_acc(v.sel), v.exp_acc);
    chk($sformatf("v%0d_ovf", idx), {11'd0, rd_ovf(v.sel)}, {11'd0, v.exp_ovf});
    chk($sformatf("v%0d_hold_pready", idx), {11'd0, rd_pready(v.sel)}, 12'd0);
    tick();
    chk($sformatf("v%0d_valid_drop", idx), {11'd0, rd_valid(v.sel)}, 12'd0);
    chk($sformatf("v%0d_idle_pready", idx), {11'd0, rd_pready(v.sel)}, 12'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = mk(1'b0, 9'h003, 9'h1FB, 9'h007, 9'h1FE, 12'h003, 1'b0);
    vecs[1] = mk(1'b0, 9'h180, 9'h180, 9'h180, 9'h180, 12'hE00, 1'b0);
    vecs[2] = mk(1'b0, 9'h0FF, 9'h0FF, 9'h0FF, 9'h100, 12'h1FD, 1'b0);
    vecs[3] = mk(1'b0, 9'h100, 9'h100, 9'h100, 9'h100, 12'hC00, 1'b0);
`ifdef MAC_ACCUM_SAT_EN
    vecs[4] = mk(1'b1, 9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF, 12'h1FF, 1'b1);
`else
    vecs[4] = mk(1'b1, 9'h0FF, 9'h0FF, 9'h0FF, 9'h0FF, 12'h3FC, 1'b1);
`endif
    vecs[5] = mk(1'b1, 9'h001, 9'h001, 9'h001, 9'h001, 12'h004, 1'b0);
`ifdef MAC_ACCUM_SAT_EN
    vecs[6] = mk(1'b1, 9'h100, 9'h100, 9'h100, 9'h100, 12'h200, 1'b1);
`else
    vecs[6] = mk(1'b1, 9'h100, 9'h100, 9'h100, 9'h100, 12'h000, 1'b1);
`endif

    ifa.prod_valid = 1'b0; ifa.prod_in = '0; ifa.acc_ready = 1'b1;
    ifb.prod_valid = 1'b0; ifb.prod_in = '0; ifb.acc_ready = 1'b1;
    clear = 1'b0;
    rst   = 1'b1;

    // Reset for two cycles.
    tick();
    tick();
    chk("rst_acc_a",   rd_acc(1'b0), 12'h000);
    chk("rst_valid_a", {11'd0, rd_valid(1'b0)}, 12'd0);
    chk("rst_ovf_a",   {11'd0, rd_ovf(1'b0)}, 12'd0);
    chk("rst_acc_b",   rd_acc(1'b1), 12'h000);
    rst = 1'b0;
    tick();
    chk("rst_pready_a", {11'd0, rd_pready(1'b0)}, 12'd1);
    chk("rst_pready_b", {11'd0, rd_pready(1'b1)}, 12'd1);

    // Table-driven groups.
    for (int i = 0; i < 7; i++) begin
      apply_vec(i, vecs[i]);
    end

    // Backpressure: result held while downstream stalls, pending 5 waits.
    feed_a(9'h003, 9'h1FB, 9'h007, 9'h1FE, 1'b0);
    drive(1'b0, 1'b1, 9'd5, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid",  {11'd0, rd_valid(1'b0)}, 12'd1);
      chk("bp_acc",    rd_acc(1'b0), 12'h003);
      chk("bp_pready", {11'd0, rd_pready(1'b0)}, 12'd0);
      tick();
    end
    drive(1'b0, 1'b1, 9'd5, 1'b1);
    chk("bp_release_valid",  {11'd0, rd_valid(1'b0)}, 12'd1);
    chk("bp_release_pready", {11'd0, rd_pready(1'b0)}, 12'd0);
    tick();
    chk("bp_idle_valid",  {11'd0, rd_valid(1'b0)}, 12'd0);
    chk("bp_idle_pready", {11'd0, rd_pready(1'b0)}, 12'd1);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 9'd1, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 9'd0, 1'b1);
    chk("bp_next_valid", {11'd0, rd_valid(1'b0)}, 12'd1);
    chk("bp_next_acc",   rd_acc(1'b0), 12'd8);
    tick();

    // Abort mid-group; the product offered during clear is not taken.
    drive(1'b0, 1'b1, 9'd10, 1'b1);
    tick();
    drive(1'b0, 1'b1, 9'd20, 1'b1);
    tick();
    clear = 1'b1;
    drive(1'b0, 1'b1, 9'd99, 1'b1);
    chk("clr_pready", {11'd0, rd_pready(1'b0)}, 12'd0);
    tick();
    clear = 1'b0;
    #1;
    chk("clr_acc", rd_acc(1'b0), 12'd0);
    feed_a(9'd1, 9'd2, 9'd3, 9'd4, 1'b1);
    drive(1'b0, 1'b0, 9'd0, 1'b1);
    chk("clr_next_valid", {11'd0, rd_valid(1'b0)}, 12'd1);
    chk("clr_next_acc",   rd_acc(1'b0), 12'd10);
    tick();

    // Abort while a result is pending in HOLD.
    feed_a(9'd1, 9'd1, 9'd1, 9'd1, 1'b0);
    drive(1'b0, 1'b0, 9'd0, 1'b0);
    chk("clrh_valid_pre", {11'd0, rd_valid(1'b0)}, 12'd1);
    chk("clrh_acc_pre",   rd_acc(1'b0), 12'd4);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1;
    chk("clrh_valid", {11'd0, rd_valid(1'b0)}, 12'd0);
    chk("clrh_acc",   rd_acc(1'b0), 12'd0);
    chk("clrh_ovf",   {11'd0, rd_ovf(1'b0)}, 12'd0);
    chk("clrh_pready", {11'd0, rd_pready(1'b0)}, 12'd1);
    tick();
    chk("clrh_valid_later", {11'd0, rd_valid(1'b0)}, 12'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mac_accum.md
# mac_accum

Signed multiply-accumulate back end that consumes the product of the signed N×M array multiplier and sums `K` consecutive products into one dot-product result. It sits directly downstream of the multiplier. It registers each accepted product into a wide accumulator, counts terms, and presents the finished sum on a valid/ready output port. The multiplier stays purely combinational; all sequencing, backpressure and overflow handling live here.

## Interface
Parameters:
- `N`, 4: width of multiplier operand A.
- `M`, 5: width of multiplier operand B.
- `P`, N+M: product width (derived; do not override).
- `K`, 4: products summed per result; legal range 1..255.
- `ACC_W`, 12: accumulator and result width; must satisfy ACC_W ≥ P.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `clear`  in  1  synchronous abort of the current group.
- `prod_in`  in  P  signed two's-complement product from the multiplier.
- `prod_valid`  in  1  `prod_in` is valid this cycle.
- `prod_ready`  out  1  block accepts `prod_in` this cycle.
- `acc_out`  out  ACC_W  signed dot-product result.
- `acc_valid`  out  1  `acc_out` holds a finished result.
- `acc_ready`  in  1  downstream takes `acc_out`.
- `ovf`  out  1  overflow occurred in the presented group.

## Operation
- A product is accepted when `prod_valid && prod_ready`. A result is taken when `acc_valid && acc_ready`.
- Each accepted `prod_in` is sign-extended from P to ACC_W bits before it is added.
- FSM states:
  - **IDLE**: `prod_ready`=1. On accept: acc ← sext(prod_in), cnt ← 1. Go to HOLD if K==1, else go to ACCUM.
  - **ACCUM**: `prod_ready`=1. On accept: acc ← acc + sext(prod_in), cnt ← cnt+1. If the accepted term is the K-th, go to HOLD. With no accept, hold all state.
  - **HOLD**: `acc_valid`=1, `prod_ready`=0. `acc_out`, `ovf` and cnt are frozen. On `acc_ready`, go to IDLE.
- Overflow is detected on each add as a signed ACC_W overflow (the operands have the same sign and the result sign differs).
  - `ovf` is sticky within a group.
  - `ovf` is cleared when the first term of the next group is accepted.
- `clear` takes priority over every other event except `rst`:
  - Next state is IDLE; acc, cnt and `ovf` go to 0.
  - `prod_ready` is forced to 0 in the cycle `clear` is high, so no product is accepted that cycle.
  - A result pending in HOLD is discarded.
- `rst`: state IDLE, `acc_out`=0, cnt=0, `acc_valid`=0, `ovf`=0. `prod_ready` is 1 from the first cycle after reset deasserts.

## Timing
- `prod_ready` and `acc_valid` are combinational decodes of the registered state (and `clear`). `acc_out` and `ovf` come straight from registers.
- Latency: when the K-th term is accepted at edge t, `acc_valid`=1 in the cycle after edge t.
- Minimum group period is K+1 cycles: K accept cycles plus 1 HOLD cycle with `acc_ready`=1. HOLD never accepts a product.
- While `acc_ready`=0 in HOLD, `acc_out` and `acc_valid` stay stable.
- A `prod_valid` pulse with `prod_ready`=0 has no effect; the producer must hold the data.

## Configuration
- `MAC_ACCUM_SAT_EN` defined: on overflow, acc clamps to the signed ACC_W maximum (2^(ACC_W-1)-1) or minimum (-2^(ACC_W-1)), matching the sign of the operands. Later adds continue from the clamped value. `ovf`=1.
- `MAC_ACCUM_SAT_EN` undefined: acc wraps modulo 2^ACC_W. `ovf` is still flagged.

## Test plan
All scenarios use N=4, M=5, K=4, ACC_W=12 unless stated otherwise.
1. Reset: hold `rst` for 2 cycles → `acc_out`=0, `acc_valid`=0, `ovf`=0; `prod_ready`=1 on the first cycle after release.
2. Basic sum: back-to-back `prod_in` = 3, 9'h1FB (-5), 7, 9'h1FE (-2) with `acc_ready`=1 → one cycle after the 4th accept, `acc_valid`=1 and `acc_out`=12'h003 for exactly 1 cycle; then IDLE.
3. Backpressure: same stimulus, `acc_ready`=0 for 3 cycles while `prod_valid`=1 with value 5 → `acc_out` stays 3 and `prod_ready`=0 throughout. After `acc_ready` rises, the 5 is accepted as term 1 of the next group.
4. Negative sum: four terms of 9'h180 (-128) → `acc_out`=12'hE00 (-512), `ovf`=0.
5. Overflow with ACC_W=10: four terms of 255.
   - With `MAC_ACCUM_SAT_EN`: `acc_out`=10'h1FF (511), `ovf`=1.
   - Without it: `acc_out`=10'h3FC (-4), `ovf`=1.
   - The next group of 1, 1, 1, 1 gives `acc_out`=4 and `ovf`=0.
6. Abort: accept 10 and 20, then pulse `clear` while `prod_valid`=1 with 99 → 99 is not accepted. Follow with 1, 2, 3, 4 → `acc_out`=10. Also pulse `clear` in HOLD → `acc_valid` drops the next cycle and no result is taken.
